fisr_newton_ctrl: RTL

- Sequencer for the fast-inverse-square-root core.
- Accepts one IEEE-754 single-precision operand per transaction and computes the magic-constant seed y0 = 0x5F3759DF - (x >> 1).
- Runs ITER Newton steps y = y*(1.5 - (x/2)*y*y) by time-sharing one external fixed-latency FP multiplier and the fixed-latency 1.5-minus subtraction stage.
- Returns the result over a valid/ready handshake.

---
 rtl/fisr_newton_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/fisr_newton_ctrl.sv
// Fast inverse square root sequencer: magic-constant seed plus Newton steps
// time-shared over one external multiplier and one 1.5-minus stage.
module fisr_newton_ctrl #(
    parameter int ITER    = 1,
    parameter int MUL_LAT = 2,
    parameter int SUB_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_err,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_res,
    output logic        sub_start,
    output logic [31:0] sub_b,
    input  logic [31:0] sub_res
);

    localparam int LMAX = (MUL_LAT > SUB_LAT) ? MUL_LAT : SUB_LAT;
    localparam int CW   = $clog2(LMAX + 1);

    localparam logic [CW-1:0] MUL_END  = CW'(MUL_LAT);
    localparam logic [CW-1:0] SUB_END  = CW'(SUB_LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    ITER_END = 4'(ITER);
    localparam logic [31:0]   MAGIC    = 32'h5F3759DF;
    localparam logic [31:0]   QNAN     = 32'h7FC00000;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        MUL_XY,
        MUL_TY,
        SUB,
        MUL_YS,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [31:0]   x;
    logic [31:0]   xh;
    logic [31:0]   y;
    logic [31:0]   t;
    logic [31:0]   s;
    logic          err;
    logic [CW-1:0] wcnt;
    logic [3:0]    iter_cnt;
    logic [3:0]    iter_inc;
    logic          op_state;
    logic          issue;
    logic          lat_hit;
    logic          bad_op;
    logic          last_iter;

    assign op_state = (state == MUL_XY) || (state == MUL_TY) ||
                      (state == SUB)    || (state == MUL_YS);

    assign issue = op_state && (wcnt == '0);

    assign lat_hit = op_state &&
                     (wcnt == ((state == SUB) ? SUB_END : MUL_END));

    // Negative, zero/denormal and inf/NaN operands have no real 1/sqrt
    assign bad_op = x[31] || (x[30:23] == 8'h00) || (x[30:23] == 8'hFF);

    assign iter_inc  = iter_cnt + 4'd1;
    assign last_iter = (iter_inc == ITER_END);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = SEED;
                end
            end
            SEED: begin
                state_nx = bad_op ? DONE : MUL_XY;
            end
            MUL_XY: begin
                if (lat_hit) begin
                    state_nx = MUL_TY;
                end
            end
            MUL_TY: begin
                if (lat_hit) begin
                    state_nx = SUB;
                end
            end
            SUB: begin
                if (lat_hit) begin
                    state_nx = MUL_YS;
                end
            end
            MUL_YS: begin
                if (lat_hit) begin
                    state_nx = last_iter ? DONE : MUL_XY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Wait counter restarts at zero on entry to every op state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else if (op_state && !lat_hit) begin
            wcnt <= wcnt + CNT_ONE;
        end else begin
            wcnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x        <= '0;
            xh       <= '0;
            y        <= '0;
            t        <= '0;
            s        <= '0;
            err      <= 1'b0;
            iter_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        x   <= in_data;
                        err <= 1'b0;
                    end
                end
                SEED: begin
                    xh       <= {x[31], x[30:23] - 8'd1, x[22:0]};
                    iter_cnt <= '0;
                    if (bad_op) begin
                        y   <= QNAN;
                        err <= 1'b1;
                    end else begin
                        y <= MAGIC - (x >> 1);
                    end
                end
                MUL_XY, MUL_TY: begin
                    if (lat_hit) begin
                        t <= mul_res;
                    end
                end
                SUB: begin
                    if (lat_hit) begin
                        s <= sub_res;
                    end
                end
                MUL_YS: begin
                    if (lat_hit) begin
                        y        <= mul_res;
                        iter_cnt <= iter_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_err   = 1'b0;
        mul_start = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        sub_start = 1'b0;
        sub_b     = '0;
        unique case (state)
            IDLE: begin
                in_ready = ~rst;
            end
            MUL_XY: begin
                mul_start = issue;
                mul_a     = xh;
                mul_b     = y;
            end
            MUL_TY: begin
                mul_start = issue;
                mul_a     = t;
                mul_b     = y;
            end
            SUB: begin
                sub_start = issue;
                sub_b     = t;
            end
            MUL_YS: begin
                mul_start = issue;
                mul_a     = y;
                mul_b     = s;
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = y;
                out_err   = err;
            end
            default: begin
            end
        endcase
    end

endmodule
